// File: rtl/img_uart_xfer_pkg.sv
// Shared register map, bit positions and state/mode/op enums for the
// UART <-> frame-memory transfer engine.
package img_uart_pkg;
   localparam logic [4:0] RX_BASE     = 5'd0;
   localparam logic [4:0] TX_BASE     = 5'd4;
   localparam logic [4:0] STATUS_BASE = 5'd8;
   localparam int         TX_OK_BIT   = 6;
   localparam int         RX_OK_BIT   = 7;

   typedef enum logic [3:0] {
      S_IDLE, S_RX_POLL, S_RX_READ, S_WR, S_RD_REQ,
      S_RD_WAIT, S_TX_POLL, S_TX_WRITE, S_DONE
   } state_e;

   typedef enum logic {MODE_LOAD = 1'b0, MODE_DUMP = 1'b1} mode_e;

   typedef enum logic [1:0] {OP_NONE, OP_POLL, OP_RX, OP_TX} avm_op_e;
endpackage

// File: rtl/img_uart_xfer_if.sv
// Avalon-MM connection between the transfer engine and the RS-232 UART slave.
interface img_uart_xfer_if;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;

   modport master (
      output avm_address, avm_read, avm_write, avm_writedata,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_read, avm_write, avm_writedata,
      output avm_readdata, avm_waitrequest
   );
endinterface

// File: rtl/img_uart_xfer_avm_port.sv
// Avalon-side driver: turns a poll/rx/tx request into bus signals and reports
// completion plus the UART status bits and received byte.
module uart_avm_port
   import img_uart_pkg::*;
(
   img_uart_xfer_if.master bus,
   input  avm_op_e         op,
   input  logic [7:0]      tx_byte,
   output logic            done,
   output logic [7:0]      rx_byte,
   output logic            rx_ok,
   output logic            tx_ok
);
   logic unused_rdata;

   // Bus outputs depend only on the requested op, which the FSM holds constant
   // while waitrequest is high, so they stay stable across stalls.
   assign bus.avm_address   = (op == OP_RX) ? RX_BASE :
                              (op == OP_TX) ? TX_BASE : STATUS_BASE;
   assign bus.avm_read      = (op == OP_POLL) || (op == OP_RX);
   assign bus.avm_write     = (op == OP_TX);
   assign bus.avm_writedata = (op == OP_TX) ? {24'b0, tx_byte} : 32'b0;

   assign done         = (op != OP_NONE) && !bus.avm_waitrequest;
   assign rx_byte      = bus.avm_readdata[7:0];
   assign rx_ok        = bus.avm_readdata[RX_OK_BIT];
   assign tx_ok        = bus.avm_readdata[TX_OK_BIT];
   assign unused_rdata = ^bus.avm_readdata[31:8];
endmodule

// File: rtl/img_uart_xfer.sv
// Frame transfer engine: loads a HEIGHT x WIDTH frame from the UART into
// memory, or dumps it from memory to the UART, BYTES_PER_PIX bytes MSB-first.
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_RX_POLL  | polling STATUS for RX data available
// S_RX_READ  | reading one RX byte into the pixel shifter
// S_WR       | writing the packed pixel to memory
// S_RD_REQ   | issuing the memory read for the next pixel
// S_RD_WAIT  | capturing memory read data
// S_TX_POLL  | polling STATUS for TX space
// S_TX_WRITE | sending the top byte of the pixel shifter
// S_DONE     | one-cycle o_fin, back to idle
module img_uart_xfer
   import img_uart_pkg::*;
#(
   parameter  int HEIGHT        = 480,
   parameter  int WIDTH         = 800,
   parameter  int BYTES_PER_PIX = 2,
   localparam int PIX_W         = 8 * BYTES_PER_PIX,
   localparam int NPIX          = HEIGHT * WIDTH,
   localparam int ADDR_W        = $clog2(HEIGHT * WIDTH)
) (
   input  logic              avm_clk,
   input  logic              avm_rst_n,
   input  logic              i_start,
   input  logic              i_mode,
   input  logic              i_abort,
   img_uart_xfer_if.master   avm,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [PIX_W-1:0]  o_wr_data,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [PIX_W-1:0]  i_rd_data,
   output logic              o_busy,
   output logic [ADDR_W:0]   o_pix_cnt,
   output logic              o_fin
);
   localparam int CNT_W = ADDR_W + 1;

   state_e           state_q, state_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic             abort_q, abort_d;

   avm_op_e          op;
   logic             xfer_done, rx_ok, tx_ok;
   logic [7:0]       rx_byte;

   logic abort_now, last_byte, last_pix;
   assign abort_now = abort_q | i_abort;
   assign last_byte = (bcnt_q == 2'(BYTES_PER_PIX - 1));
   assign last_pix  = (pix_cnt_q == CNT_W'(NPIX - 1));

   uart_avm_port u_port (
      .bus     (avm),
      .op      (op),
      .tx_byte (pix_q[PIX_W-1 -: 8]),
      .done    (xfer_done),
      .rx_byte (rx_byte),
      .rx_ok   (rx_ok),
      .tx_ok   (tx_ok)
   );

   always_ff @(posedge avm_clk) begin
      if (!avm_rst_n) begin
         state_q   <= S_IDLE;
         pix_q     <= '0;
         bcnt_q    <= '0;
         pix_cnt_q <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_q     <= pix_d;
         bcnt_q    <= bcnt_d;
         pix_cnt_q <= pix_cnt_d;
         abort_q   <= abort_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      bcnt_d    = bcnt_q;
      pix_cnt_d = pix_cnt_q;
      // abort is only remembered while busy; an abort coinciding with start is dropped
      abort_d   = (state_q == S_IDLE) ? 1'b0 : abort_now;
      op        = OP_NONE;
      o_wr_en   = 1'b0;
      o_rd_en   = 1'b0;
      o_fin     = 1'b0;
      case (state_q)
         S_IDLE: if (i_start) begin
            pix_cnt_d = '0;
            bcnt_d    = '0;
            pix_d     = '0;
            state_d   = (mode_e'(i_mode) == MODE_DUMP) ? S_RD_REQ : S_RX_POLL;
         end
         S_RX_POLL: begin
            op = OP_POLL;
            if (xfer_done) begin
               if (abort_now)  state_d = S_DONE;
               else if (rx_ok) state_d = S_RX_READ;
            end
         end
         S_RX_READ: begin
            op = OP_RX;
            if (xfer_done) begin
               pix_d  = (pix_q << 8) | PIX_W'(rx_byte);
               bcnt_d = bcnt_q + 2'd1;
               // a completed pixel is still written; S_WR then honours the abort
               if (last_byte)      state_d = S_WR;
               else if (abort_now) state_d = S_DONE;
               else                state_d = S_RX_POLL;
            end
         end
         S_WR: begin
            o_wr_en   = 1'b1;
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            bcnt_d    = '0;
            state_d   = (last_pix || abort_now) ? S_DONE : S_RX_POLL;
         end
         S_RD_REQ: begin
            o_rd_en = 1'b1;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            pix_d   = i_rd_data;
            bcnt_d  = '0;
            state_d = abort_now ? S_DONE : S_TX_POLL;
         end
         S_TX_POLL: begin
            op = OP_POLL;
            if (xfer_done) begin
               if (abort_now)  state_d = S_DONE;
               else if (tx_ok) state_d = S_TX_WRITE;
            end
         end
         S_TX_WRITE: begin
            op = OP_TX;
            if (xfer_done) begin
               pix_d  = pix_q << 8;
               bcnt_d = bcnt_q + 2'd1;
               if (last_byte) begin
                  pix_cnt_d = pix_cnt_q + CNT_W'(1);
                  bcnt_d    = '0;
                  state_d   = (last_pix || abort_now) ? S_DONE : S_RD_REQ;
               end else begin
                  state_d   = abort_now ? S_DONE : S_TX_POLL;
               end
            end
         end
         S_DONE: begin
            o_fin   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // addresses are gated so the post-frame count (NPIX) never appears on them
   assign o_wr_addr = o_wr_en ? pix_cnt_q[ADDR_W-1:0] : '0;
   assign o_rd_addr = o_rd_en ? pix_cnt_q[ADDR_W-1:0] : '0;
   assign o_wr_data = pix_q;
   assign o_busy    = (state_q != S_IDLE);
   assign o_pix_cnt = pix_cnt_q;
endmodule

// File: tb/tb_img_uart_xfer.sv
// Bench for img_uart_xfer: a 2x3 BPP=2 instance against a UART model with
// stalls and not-ready polls, plus small BPP=3 and BPP=1 load instances.
module tb_img_uart_xfer;
   import img_uart_pkg::*;

   logic avm_clk = 1'b0;
   logic avm_rst_n;
   always #5 avm_clk = ~avm_clk;

   // ---------------- DUT A: 2x3, BPP=2 ----------------
   logic        i_start, i_mode, i_abort;
   logic        a_wr_en, a_rd_en, a_busy, a_fin;
   logic [2:0]  a_wr_addr, a_rd_addr;
   logic [15:0] a_wr_data, a_rd_data;
   logic [3:0]  a_pix_cnt;
   img_uart_xfer_if a_if();

   img_uart_xfer #(.HEIGHT(2), .WIDTH(3), .BYTES_PER_PIX(2)) dut_a (
      .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .i_start(i_start), .i_mode(i_mode),
      .i_abort(i_abort), .avm(a_if), .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr),
      .o_wr_data(a_wr_data), .o_rd_en(a_rd_en), .o_rd_addr(a_rd_addr),
      .i_rd_data(a_rd_data), .o_busy(a_busy), .o_pix_cnt(a_pix_cnt), .o_fin(a_fin));

   int ws_cfg, nrdy_cfg;
   logic tb_clr;
   int stall_cnt, nrdy_cnt, rx_idx, tx_cnt, wr_cnt, fin_cnt, nopoll_err, stab_err;
   bit poll_ok, prev_wait;
   logic [38:0] prev_bus;
   logic [7:0]  rx_mem [16];
   logic [31:0] tx_log [16];
   logic [15:0] wmem [8];
   logic [2:0]  wlog [8];
   logic [15:0] rmem [8];
   logic [15:0] a_rd_q;

   assign a_if.avm_waitrequest = (a_if.avm_read || a_if.avm_write) && (stall_cnt != ws_cfg);
   assign a_if.avm_readdata =
      (a_if.avm_address == 5'd8) ? {24'b0, (nrdy_cnt == 0 && rx_idx < 16), (nrdy_cnt == 0), 6'b0} :
      (a_if.avm_address == 5'd0) ? {24'b0, rx_mem[rx_idx[3:0]]} : 32'h0;
   assign a_rd_data = a_rd_q;

   always @(posedge avm_clk) if (a_rd_en) a_rd_q <= rmem[a_rd_addr];

   always @(posedge avm_clk) begin
      if (tb_clr) begin
         stall_cnt <= 0; nrdy_cnt <= nrdy_cfg; rx_idx <= 0; tx_cnt <= 0; wr_cnt <= 0;
         fin_cnt <= 0; nopoll_err <= 0; stab_err <= 0; poll_ok <= 0; prev_wait <= 0;
         for (int i = 0; i < 8; i++) wmem[i] <= 16'hDEAD;
      end else begin
         if (a_if.avm_read || a_if.avm_write) begin
            if (a_if.avm_waitrequest) stall_cnt <= stall_cnt + 1;
            else begin
               stall_cnt <= 0;
               if (a_if.avm_read && a_if.avm_address == 5'd8) begin
                  if (nrdy_cnt != 0) nrdy_cnt <= nrdy_cnt - 1;
                  else poll_ok <= 1'b1;
               end else if (a_if.avm_read && a_if.avm_address == 5'd0) begin
                  rx_idx <= rx_idx + 1; nrdy_cnt <= nrdy_cfg; poll_ok <= 1'b0;
               end else if (a_if.avm_write && a_if.avm_address == 5'd4) begin
                  if (tx_cnt < 16) tx_log[tx_cnt] <= a_if.avm_writedata;
                  tx_cnt <= tx_cnt + 1; nrdy_cnt <= nrdy_cfg; poll_ok <= 1'b0;
                  if (!poll_ok) nopoll_err <= nopoll_err + 1;
               end
            end
         end
         if (a_wr_en) begin
            wmem[a_wr_addr] <= a_wr_data;
            if (wr_cnt < 8) wlog[wr_cnt] <= a_wr_addr;
            wr_cnt <= wr_cnt + 1;
         end
         if (a_fin) fin_cnt <= fin_cnt + 1;
         if (prev_wait && prev_bus != {a_if.avm_address, a_if.avm_read, a_if.avm_write, a_if.avm_writedata})
            stab_err <= stab_err + 1;
         prev_wait <= a_if.avm_waitrequest;
         prev_bus  <= {a_if.avm_address, a_if.avm_read, a_if.avm_write, a_if.avm_writedata};
      end
   end

   // ---------------- DUT B (1x2, BPP=3) and C (1x3, BPP=1), always-ready UART ----------------
   logic        b_start, b_wr_en, b_rd_en, b_busy, b_fin, c_wr_en, c_rd_en, c_busy, c_fin;
   logic [0:0]  b_wr_addr, b_rd_addr;
   logic [1:0]  b_pix_cnt, c_wr_addr, c_rd_addr;
   logic [23:0] b_wr_data;
   logic [23:0] b_rd_data = '0;
   logic [7:0]  c_wr_data;
   logic [7:0]  c_rd_data = '0;
   logic [2:0]  c_pix_cnt;
   logic        zero = 1'b0;
   logic [7:0]  rxb [8];
   logic [23:0] b_wdata [2];
   logic [7:0]  c_wdata [4];
   int b_idx, c_idx, b_wcnt, c_wcnt;
   img_uart_xfer_if b_if();
   img_uart_xfer_if c_if();

   img_uart_xfer #(.HEIGHT(1), .WIDTH(2), .BYTES_PER_PIX(3)) dut_b (
      .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .i_start(b_start), .i_mode(zero),
      .i_abort(zero), .avm(b_if), .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr),
      .o_wr_data(b_wr_data), .o_rd_en(b_rd_en), .o_rd_addr(b_rd_addr),
      .i_rd_data(b_rd_data), .o_busy(b_busy), .o_pix_cnt(b_pix_cnt), .o_fin(b_fin));

   img_uart_xfer #(.HEIGHT(1), .WIDTH(3), .BYTES_PER_PIX(1)) dut_c (
      .avm_clk(avm_clk), .avm_rst_n(avm_rst_n), .i_start(b_start), .i_mode(zero),
      .i_abort(zero), .avm(c_if), .o_wr_en(c_wr_en), .o_wr_addr(c_wr_addr),
      .o_wr_data(c_wr_data), .o_rd_en(c_rd_en), .o_rd_addr(c_rd_addr),
      .i_rd_data(c_rd_data), .o_busy(c_busy), .o_pix_cnt(c_pix_cnt), .o_fin(c_fin));

   assign b_if.avm_waitrequest = 1'b0;
   assign c_if.avm_waitrequest = 1'b0;
   assign b_if.avm_readdata = (b_if.avm_address == 5'd8) ? 32'hC0 : {24'b0, rxb[b_idx[2:0]]};
   assign c_if.avm_readdata = (c_if.avm_address == 5'd8) ? 32'hC0 : {24'b0, rxb[c_idx[2:0]]};

   always @(posedge avm_clk) begin
      if (!avm_rst_n) begin
         b_idx <= 0; c_idx <= 0; b_wcnt <= 0; c_wcnt <= 0;
      end else begin
         if (b_if.avm_read && b_if.avm_address == 5'd0) b_idx <= b_idx + 1;
         if (c_if.avm_read && c_if.avm_address == 5'd0) c_idx <= c_idx + 1;
         if (b_wr_en) begin b_wdata[b_wr_addr] <= b_wr_data; b_wcnt <= b_wcnt + 1; end
         if (c_wr_en) begin c_wdata[c_wr_addr] <= c_wr_data; c_wcnt <= c_wcnt + 1; end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " avm_address"}, 32'(a_if.avm_address), 32'd8);
      check({tag, " avm_read/write"}, {30'b0, a_if.avm_read, a_if.avm_write}, 32'd0);
      check({tag, " avm_writedata"}, a_if.avm_writedata, 32'd0);
      check({tag, " mem strobes"}, {30'b0, a_wr_en, a_rd_en}, 32'd0);
      check({tag, " mem addr/data"}, {10'b0, a_wr_addr, a_rd_addr, a_wr_data}, 32'd0);
      check({tag, " busy/fin"}, {30'b0, a_busy, a_fin}, 32'd0);
      check({tag, " pix_cnt"}, 32'(a_pix_cnt), 32'd0);
   endtask

   typedef struct {
      logic mode;
      int   ws;
      int   nrdy;
      int   abort_at;
      int   exp_wr;
      int   exp_tx;
      int   exp_pcnt;
   } vec_t;
   vec_t vecs [6];

   task automatic run_vec(input int vi);
      vec_t v;
      int   cyc;
      bit   fired;
      logic [15:0] ep;
      logic [31:0] et;
      v = vecs[vi];
      @(negedge avm_clk); ws_cfg = v.ws; nrdy_cfg = v.nrdy; tb_clr = 1'b1;
      @(negedge avm_clk); tb_clr = 1'b0; i_mode = v.mode; i_start = 1'b1;
      @(negedge avm_clk); i_start = 1'b0;
      cyc = 0; fired = 0;
      while (fin_cnt == 0 && cyc < 4000) begin
         i_abort = 1'b0;
         if (v.abort_at >= 0 && !fired && rx_idx == v.abort_at) begin
            i_abort = 1'b1; fired = 1;
         end
         @(negedge avm_clk); cyc++;
      end
      i_abort = 1'b0;
      repeat (3) @(negedge avm_clk);
      check($sformatf("v%0d fin pulses", vi), 32'(fin_cnt), 32'd1);
      check($sformatf("v%0d busy after", vi), 32'(a_busy), 32'd0);
      check($sformatf("v%0d mem writes", vi), 32'(wr_cnt), 32'(v.exp_wr));
      check($sformatf("v%0d tx writes", vi), 32'(tx_cnt), 32'(v.exp_tx));
      check($sformatf("v%0d pix_cnt", vi), 32'(a_pix_cnt), 32'(v.exp_pcnt));
      check($sformatf("v%0d stall stability", vi), 32'(stab_err), 32'd0);
      check($sformatf("v%0d tx without ok poll", vi), 32'(nopoll_err), 32'd0);
      for (int i = 0; i < v.exp_wr && i < 8; i++) begin
         ep = {8'(2 * i), 8'(2 * i + 1)};
         check($sformatf("v%0d wr_addr[%0d]", vi, i), 32'(wlog[i]), 32'(i));
         check($sformatf("v%0d wr_data[%0d]", vi, i), 32'(wmem[i]), 32'(ep));
      end
      for (int k = 0; k < v.exp_tx && k < 16; k++) begin
         et = (k % 2 == 0) ? 32'hA0 : 32'(8'hB0 + 8'(k / 2));
         check($sformatf("v%0d tx[%0d]", vi, k), tx_log[k], et);
      end
   endtask

   initial begin
      int cyc;
      avm_rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_abort = 1'b0; b_start = 1'b0;
      tb_clr = 1'b1; ws_cfg = 0; nrdy_cfg = 0;
      for (int i = 0; i < 16; i++) rx_mem[i] = 8'(i);
      for (int i = 0; i < 8; i++) rmem[i] = 16'hA0B0 + 16'(i);
      for (int i = 0; i < 8; i++) rxb[i] = 8'(8'h11 * (i + 1));
      // mode, ws, nrdy, abort_at, exp_wr, exp_tx, exp_pcnt
      vecs[0] = '{1'b0, 0, 0, -1, 6,  0, 6};
      vecs[1] = '{1'b0, 3, 2, -1, 6,  0, 6};
      vecs[2] = '{1'b1, 0, 0, -1, 0, 12, 6};
      vecs[3] = '{1'b1, 2, 1, -1, 0, 12, 6};
      vecs[4] = '{1'b0, 0, 0,  3, 1,  0, 1};
      vecs[5] = '{1'b0, 0, 0, -1, 6,  0, 6};

      repeat (3) @(negedge avm_clk);
      check_reset_outputs("reset");
      avm_rst_n = 1'b1; tb_clr = 1'b0;
      @(negedge avm_clk); b_start = 1'b1;
      @(negedge avm_clk); b_start = 1'b0;

      for (int vi = 0; vi < 6; vi++) run_vec(vi);

      check("bpp3 writes", 32'(b_wcnt), 32'd2);
      check("bpp3 pix0", 32'(b_wdata[0]), 32'h112233);
      check("bpp3 pix1", 32'(b_wdata[1]), 32'h445566);
      check("bpp3 pix_cnt", 32'(b_pix_cnt), 32'd2);
      check("bpp1 writes", 32'(c_wcnt), 32'd3);
      check("bpp1 pixels", {8'b0, c_wdata[0], c_wdata[1], c_wdata[2]}, 32'h112233);
      check("bpp1 pix_cnt", 32'(c_pix_cnt), 32'd3);

      // mid-dump: a second start is ignored, then a one-cycle reset
      @(negedge avm_clk); ws_cfg = 0; nrdy_cfg = 0; tb_clr = 1'b1;
      @(negedge avm_clk); tb_clr = 1'b0; i_mode = 1'b1; i_start = 1'b1;
      @(negedge avm_clk); i_start = 1'b0;
      cyc = 0;
      while (tx_cnt < 3 && cyc < 500) begin @(negedge avm_clk); cyc++; end
      i_mode = 1'b0; i_start = 1'b1;
      @(negedge avm_clk); i_start = 1'b0;
      cyc = 0;
      while (tx_cnt < 6 && cyc < 500) begin @(negedge avm_clk); cyc++; end
      check("busy start ignored: tx count", 32'(tx_cnt), 32'd6);
      check("busy start ignored: no mem writes", 32'(wr_cnt), 32'd0);
      check("busy start ignored: busy", 32'(a_busy), 32'd1);
      check("busy start ignored: tx[5]", tx_log[5], 32'hB2);
      avm_rst_n = 1'b0;
      @(negedge avm_clk);
      check_reset_outputs("mid-dump reset");
      avm_rst_n = 1'b1;
      repeat (4) @(negedge avm_clk);
      check("after reset idle", {30'b0, a_busy, a_if.avm_write}, 32'd0);
      check("after reset no fin", 32'(fin_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/img_uart_xfer.md
Name: img_uart_xfer

Overview:
Parametrised successor of the frame-loading block: moves a HEIGHT×WIDTH frame between the RS-232 Avalon-MM slave and frame memory.
- Mode 0 (load): polls STATUS, reads RX bytes, packs BYTES_PER_PIX bytes per pixel MSB-first, writes each pixel to memory.
- Mode 1 (dump): reads each pixel from memory and transmits it over TX, MSB-first.
- Sits between the UART IP and the SRAM/frame-buffer arbiter; supports abort and a pixel-progress output.

Parameters:
HEIGHT, 480, frame rows
WIDTH, 800, frame columns
BYTES_PER_PIX, 2, bytes per pixel (1..4)
PIX_W, 8*BYTES_PER_PIX, pixel width (derived, not overridden)
NPIX, HEIGHT*WIDTH, pixels per frame (derived)
ADDR_W, $clog2(HEIGHT*WIDTH), pixel address width (derived)

Ports:
avm_clk  in  1  single clock
avm_rst_n  in  1  synchronous, active-low reset
i_start  in  1  start pulse, sampled only in S_IDLE
i_mode  in  1  0 = load (UART→mem), 1 = dump (mem→UART); sampled with i_start
i_abort  in  1  stop after the current Avalon transfer completes
avm_address  out  5  0 = RX, 4 = TX, 8 = STATUS
avm_read  out  1  Avalon read
avm_readdata  in  32  Avalon read data
avm_write  out  1  Avalon write
avm_writedata  out  32  {24'b0, byte}
avm_waitrequest  in  1  Avalon stall
o_wr_en  out  1  memory write strobe
o_wr_addr  out  ADDR_W  memory write address
o_wr_data  out  PIX_W  packed pixel
o_rd_en  out  1  memory read strobe
o_rd_addr  out  ADDR_W  memory read address
i_rd_data  in  PIX_W  valid exactly 1 cycle after o_rd_en
o_busy  out  1  high outside S_IDLE
o_pix_cnt  out  ADDR_W+1  pixels completed
o_fin  out  1  1-cycle pulse: frame complete or aborted

Behaviour:
- Reset (avm_rst_n=0 at an edge): all outputs 0 except avm_address=8; state S_IDLE; counters and pixel register cleared. Reset mid-operation discards the partial pixel and frame.
- Avalon rule: while avm_waitrequest=1, avm_address/read/write/writedata are held stable; a transfer completes on the first edge where avm_waitrequest=0.
- S_IDLE: on i_start, clear pix_cnt and byte_cnt, latch mode → S_RX_POLL (mode 0) or S_RD_REQ (mode 1). i_start while busy is ignored.
- S_RX_POLL: read=1, addr=8. On completion:
  - readdata[7]=1 → S_RX_READ;
  - otherwise stay, re-issuing the read.
- S_RX_READ: read=1, addr=0. On completion, pix = {pix[PIX_W-9:0], readdata[7:0]}, byte_cnt++.
  - byte_cnt==BYTES_PER_PIX-1 → S_WR;
  - otherwise → S_RX_POLL.
- S_WR: o_wr_en=1 for exactly 1 cycle; o_wr_addr=pix_cnt, o_wr_data=pix. Then pix_cnt++, byte_cnt=0.
  - pix_cnt==NPIX-1 → S_DONE;
  - otherwise → S_RX_POLL.
- S_RD_REQ: o_rd_en=1 for 1 cycle, o_rd_addr=pix_cnt → S_RD_WAIT.
- S_RD_WAIT: capture i_rd_data into pix → S_TX_POLL.
- S_TX_POLL: read=1, addr=8. On completion:
  - readdata[6]=1 → S_TX_WRITE;
  - otherwise stay.
- S_TX_WRITE: write=1, read=0, addr=4, writedata={24'b0, pix[PIX_W-1 -: 8]}. On completion, pix <<= 8, byte_cnt++.
  - Not last byte → S_TX_POLL.
  - Last byte: pix_cnt++, byte_cnt=0; pix_cnt==NPIX-1 → S_DONE, otherwise → S_RD_REQ.
- S_DONE: o_fin=1 for 1 cycle; avm_read/avm_write=0, addr=8 → S_IDLE.
- Abort:
  - i_abort is latched (sticky) while busy and acted on only at a transfer boundary: a completed Avalon transfer, or the S_WR/S_RD_WAIT cycle → S_DONE.
  - A partial pixel is not written.
  - o_pix_cnt keeps the completed count.
- Simultaneous i_abort and i_start in S_IDLE: the start is taken; the abort is ignored.
- Wrap: pix_cnt never exceeds NPIX, and addresses never exceed NPIX-1. The next start restarts at address 0.
- In BYTES_PER_PIX=1 mode, each RX byte produces one write.

Decomposition:
- Package img_uart_pkg holds:
  - RX_BASE=0, TX_BASE=4, STATUS_BASE=8, TX_OK_BIT=6, RX_OK_BIT=7;
  - the state enum (S_IDLE, S_RX_POLL, S_RX_READ, S_WR, S_RD_REQ, S_RD_WAIT, S_TX_POLL, S_TX_WRITE, S_DONE);
  - the mode enum.
- Sub-module uart_avm_port owns the Avalon side:
  - accepts a byte request (rx or tx) and performs poll+transfer, honouring waitrequest;
  - returns a done pulse with the RX byte.
- The top-level FSM sequences pixels and drives the memory ports.

Test Plan:
- Load, HEIGHT=2, WIDTH=3, BPP=2, RX bytes 0x00..0x0B, STATUS ready on first poll → 6 writes, addr 0..5, data 0x0001, 0x0203, …, 0x0A0B; o_fin pulses once; o_pix_cnt=6.
- Load with waitrequest=1 for 3 cycles on each transfer and RX_OK=0 for 2 polls → same memory image; Avalon outputs stable during stalls.
- Dump, BPP=2, memory[i]=0xA0B0+i → TX writedata sequence 0xA0, 0xB0, 0xA0, 0xB1, …, 0xB5; 12 writes; each write preceded by a status poll with bit6=1.
- Abort after 3 RX bytes (BPP=2) → exactly 1 write (addr 0); o_fin pulses; o_pix_cnt=1; the next i_start restarts at addr 0.
- avm_rst_n=0 for 1 cycle mid-dump → all outputs take reset values next cycle; i_start while busy is ignored.
- BPP=1, BPP=3 and BPP=4 builds → bytes packed MSB-first; BPP=3 load of 0x11,0x22,0x33 → o_wr_data=0x112233.
